// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared types and constants for the OUT-register display
// Purpose: converter FSM state enum, 7-segment glyphs {g,f,e,d,c,b,a},
//          default scan divider and a BCD-digit-to-glyph helper.
// Ports:   none (package).
package sap1_pkg;

  localparam int REFRESH_DIV_DEFAULT = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } cvt_state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg_glyph = SEG_0;
      4'd1:    seg_glyph = SEG_1;
      4'd2:    seg_glyph = SEG_2;
      4'd3:    seg_glyph = SEG_3;
      4'd4:    seg_glyph = SEG_4;
      4'd5:    seg_glyph = SEG_5;
      4'd6:    seg_glyph = SEG_6;
      4'd7:    seg_glyph = SEG_7;
      4'd8:    seg_glyph = SEG_8;
      4'd9:    seg_glyph = SEG_9;
      default: seg_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 3-digit BCD converter
// Purpose: start captures bin; eight shift cycles (CONVERT) follow, then one
//          COMMIT cycle with done=1 while bcd holds the result.
// Ports:   clk, reset (async active-low), start, bin[8:0] in;
//          busy (CONVERT or COMMIT), done (COMMIT), bcd[11:0] {hund,tens,ones} out.
module bin2bcd_seq
  import sap1_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  cvt_state_t  state, state_next;
  logic [7:0]  sr;
  logic [11:0] bcd_r;
  logic [11:0] bcd_adj;
  logic [2:0]  cnt;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign bcd_adj = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
  assign bcd     = bcd_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A new start always wins, even mid-conversion or in COMMIT.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_CONVERT;
    end else begin
      case (state)
        ST_CONVERT: if (cnt == 3'd7) state_next = ST_COMMIT;
        ST_COMMIT:  state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_COMMIT);
  end

  // bin[8] is pre-shifted into the BCD register at capture (no add-3 can be
  // needed on an all-zero BCD), so eight shifts cover the full 9-bit input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr    <= '0;
      bcd_r <= '0;
      cnt   <= '0;
    end else if (start) begin
      sr    <= bin[7:0];
      bcd_r <= {11'd0, bin[8]};
      cnt   <= '0;
    end else if (state == ST_CONVERT) begin
      sr    <= sr << 1;
      bcd_r <= (bcd_adj << 1) | {11'd0, sr[7]};
      cnt   <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/out_display.sv
// rtl/out_display.sv - 4-digit multiplexed 7-segment display of the OUT register
// Purpose: captures value on load, converts to BCD via bin2bcd_seq, commits
//          whole results to display registers and scans digits 0..3.
//          Build option OUT_DISPLAY_LZB_EN blanks leading zeros (hundreds, tens).
// Ports:   clk, reset (async active-low), value[7:0], load, signed_mode in;
//          seg[6:0] {g..a}, digit_en[3:0] one-hot (bit0 = ones), busy out.
module out_display
  import sap1_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] digit_en,
  output logic       busy
);

  localparam int SCAN_W = $clog2(REFRESH_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

  logic        cap_neg;
  logic [8:0]  cap_mag;
  logic        neg_pend;
  logic        cvt_done;
  logic [11:0] cvt_bcd;

  logic [3:0]  hund_r, tens_r, ones_r;
  logic        neg_r;

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [6:0]        seg_next;

  // 9-bit magnitude so that -128 converts as 128.
  assign cap_neg = signed_mode & value[7];
  assign cap_mag = cap_neg ? (9'd256 - {1'b0, value}) : {1'b0, value};

  bin2bcd_seq u_cvt (
    .clk   (clk),
    .reset (reset),
    .start (load),
    .bin   (cap_mag),
    .busy  (busy),
    .done  (cvt_done),
    .bcd   (cvt_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) neg_pend <= 1'b0;
    else if (load) neg_pend <= cap_neg;
  end

  // A load landing on the COMMIT cycle restarts and drops this commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hund_r <= '0;
      tens_r <= '0;
      ones_r <= '0;
      neg_r  <= 1'b0;
    end else if (cvt_done && !load) begin
      hund_r <= cvt_bcd[11:8];
      tens_r <= cvt_bcd[7:4];
      ones_r <= cvt_bcd[3:0];
      neg_r  <= neg_pend;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    seg_next = SEG_BLANK;
    case (digit_idx)
      2'd0:    seg_next = seg_glyph(ones_r);
      2'd1:    seg_next = seg_glyph(tens_r);
      2'd2:    seg_next = seg_glyph(hund_r);
      default: seg_next = neg_r ? SEG_MINUS : SEG_BLANK;
    endcase
`ifdef OUT_DISPLAY_LZB_EN
    if (digit_idx == 2'd2 && hund_r == 4'd0)
      seg_next = SEG_BLANK;
    if (digit_idx == 2'd1 && hund_r == 4'd0 && tens_r == 4'd0)
      seg_next = SEG_BLANK;
`else
`endif
  end

  // seg and digit_en share one register stage so they always change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg      <= SEG_BLANK;
      digit_en <= 4'b0000;
    end else begin
      seg      <= seg_next;
      digit_en <= 4'b0001 << digit_idx;
    end
  end

endmodule

// File: tb/tb_out_display.sv
// tb/tb_out_display.sv - self-checking bench for out_display
module tb_out_display;

  localparam int D = 4;
`ifdef OUT_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] value = 8'd0;
  logic       load = 1'b0;
  logic       signed_mode = 1'b0;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  out_display #(.REFRESH_DIV(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .load        (load),
    .signed_mode (signed_mode),
    .seg         (seg),
    .digit_en    (digit_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected glyph for scan position idx showing signed decimal (neg, mag).
  function automatic logic [6:0] model_seg(input int idx, input int mag, input bit neg);
    int h, t, o;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (idx)
      0: return glyph(o);
      1: return (LZB && h == 0 && t == 0) ? 7'h00 : glyph(t);
      2: return (LZB && h == 0) ? 7'h00 : glyph(h);
      default: return neg ? 7'h40 : 7'h00;
    endcase
  endfunction

  // Model: a result becomes visible 9 edges after its load unless another
  // load arrives in between; the scan position follows the edge count.
  int k = 0, cd = 0, idx = 0;
  int disp_mag = 0, pend_mag = 0;
  bit disp_neg = 1'b0, pend_neg = 1'b0;
  logic [6:0] exp_seg = 7'h00;
  logic [3:0] exp_den = 4'h0;
  bit exp_busy = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k = 0; cd = 0; disp_mag = 0; disp_neg = 1'b0;
      exp_seg = 7'h00; exp_den = 4'h0; exp_busy = 1'b0;
    end else begin
      k++;
      idx = ((k - 1) / D) % 4;
      exp_den = 4'(1 << idx);
      exp_seg = model_seg(idx, disp_mag, disp_neg);
      if (load) begin
        pend_neg = signed_mode && value[7];
        pend_mag = pend_neg ? 256 - int'(value) : int'(value);
        cd = 9;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          disp_mag = pend_mag;
          disp_neg = pend_neg;
        end
      end
      exp_busy = (cd > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("digit_en", digit_en, exp_den);
      check("seg", seg, exp_seg);
      check("busy", busy, exp_busy);
    end
  end

  logic [6:0] cap [4];
  logic [3:0] scan_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic scan_digits();
    for (int i = 0; i < 4; i++) cap[i] = 7'h55;
    for (int i = 0; i < 4 * D; i++) begin
      @(negedge clk);
      case (digit_en)
        4'b0001: cap[0] = seg;
        4'b0010: cap[1] = seg;
        4'b0100: cap[2] = seg;
        4'b1000: cap[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic sm);
    @(posedge clk);
    #2;
    value = v;
    signed_mode = sm;
    load = 1'b1;
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  int busy_cnt;

  initial begin
    chk_en = 1'b1;
    #1;
    check("reset_den", digit_en, 0);
    check("reset_seg", seg, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("scan_den", digit_en, scan_seq[i / 4]);
      if (i == 0) check("first_seg", seg, 7'h3F);
    end

    // 255 unsigned
    do_load(8'd255, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("busy_len", busy_cnt, 9);
    scan_digits();
    check("u255_ones", cap[0], 7'h6D);
    check("u255_tens", cap[1], 7'h6D);
    check("u255_hund", cap[2], 7'h5B);
    check("u255_d3", cap[3], 7'h00);

    // -128
    do_load(8'h80, 1'b1);
    repeat (12) @(posedge clk);
    scan_digits();
    check("s80_ones", cap[0], 7'h7F);
    check("s80_tens", cap[1], 7'h5B);
    check("s80_hund", cap[2], 7'h06);
    check("s80_d3", cap[3], 7'h40);

    // -1
    do_load(8'hFF, 1'b1);
    repeat (12) @(posedge clk);
    scan_digits();
    check("sff_ones", cap[0], 7'h06);
    check("sff_tens", cap[1], LZB ? 7'h00 : 7'h3F);
    check("sff_hund", cap[2], LZB ? 7'h00 : 7'h3F);
    check("sff_d3", cap[3], 7'h40);

    // restart: 7 superseded by 42 four cycles later
    do_load(8'd7, 1'b0);
    repeat (2) @(posedge clk);
    do_load(8'd42, 1'b0);
    repeat (9) @(negedge clk);
    check("restart_busy_hi", busy, 1);
    @(negedge clk);
    check("restart_busy_lo", busy, 0);
    scan_digits();
    check("r42_ones", cap[0], 7'h5B);
    check("r42_tens", cap[1], 7'h66);
    check("r42_hund", cap[2], LZB ? 7'h00 : 7'h3F);
    check("r42_d3", cap[3], 7'h00);

    // restart landing exactly on the commit edge
    do_load(8'd11, 1'b0);
    repeat (7) @(posedge clk);
    do_load(8'd200, 1'b0);
    repeat (12) @(posedge clk);
    scan_digits();
    check("c200_ones", cap[0], 7'h3F);
    check("c200_tens", cap[1], 7'h3F);
    check("c200_hund", cap[2], 7'h5B);

    // reset mid-conversion
    do_load(8'd99, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_async_den", digit_en, 0);
    check("rst_async_seg", seg, 0);
    check("rst_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_rel_den", digit_en, 4'b0001);
    check("rst_rel_seg", seg, 7'h3F);
    repeat (20) @(posedge clk);
    scan_digits();
    check("rst_ones", cap[0], 7'h3F);
    check("rst_d3", cap[3], 7'h00);

    // sweep both modes; the compare process checks every cycle
    for (int sm = 0; sm < 2; sm++) begin
      for (int v = 0; v < 256; v++) begin
        do_load(8'(v), 1'(sm));
        repeat (26) @(posedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, meaning clk cycles each digit stays lit per scan slot (legal range >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port value  input  8  OUT-register contents from the machine.
REQ-005 SHALL have port load  input  1  capture strobe, driven by the machine's OUT-register write enable.
REQ-006 SHALL have port signed_mode  input  1  1 = interpret value as two's complement.
REQ-007 SHALL have port seg  output  7  active-high segments {g,f,e,d,c,b,a} for the lit digit.
REQ-008 SHALL have port digit_en  output  4  one-hot active-high digit select; bit 0 = ones digit.
REQ-009 SHALL have port busy  output  1  high while a conversion is in flight.

Function
REQ-010 SHALL run an FSM with states IDLE, CONVERT, COMMIT.
REQ-011 IDLE with load=1 at edge E0: capture value and signed_mode, go to CONVERT.
REQ-012 Capture: magnitude = |value| (9-bit, so -128 -> 128) and neg = value[7] if signed_mode, else magnitude = value and neg = 0.
REQ-013 CONVERT SHALL do one double-dabble shift per cycle, with add-3 on every BCD nibble >= 5, for exactly 8 cycles (E1..E8), then go to COMMIT.
REQ-014 COMMIT SHALL copy the BCD hundreds/tens/ones and the neg flag into display registers at edge E9, then return to IDLE.
REQ-015 busy SHALL be high exactly while the state is CONVERT or COMMIT, i.e. after E0 through E9.
REQ-016 Display registers SHALL change only at COMMIT; no partial or torn values appear on seg.
REQ-017 load=1 during CONVERT or COMMIT SHALL restart the conversion with the new value (latest wins), and the pending commit SHALL be dropped.
REQ-018 Scan counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-019 digit_en SHALL be the one-hot encoding of the digit index; seg SHALL be the glyph for that digit, registered in the same cycle as digit_en.
REQ-020 Digit 3 SHALL show minus (g only) when neg=1, else blank (seg=0).
REQ-021 Digits 0-2 SHALL show decimal glyphs 0-9; BCD values above 9 cannot occur.

Reset
REQ-022 reset low SHALL asynchronously set state=IDLE, busy=0, scan counter=0, digit index=0, display registers=0, neg=0, digit_en=4'b0000, seg=0.
REQ-023 The first rising clk edge after reset release SHALL set digit_en=4'b0001 and seg=glyph '0'.
REQ-024 reset asserted mid-conversion SHALL abandon the conversion; the display SHALL show 0 afterwards.

Configuration
REQ-025 With OUT_DISPLAY_LZB_EN defined: hundreds SHALL blank when 0, and tens SHALL blank when hundreds=0 and tens=0; ones is never blanked.
REQ-026 Without OUT_DISPLAY_LZB_EN: digits 0-2 SHALL always show their glyph, including leading zeros.

Structure
REQ-027 Package sap1_pkg SHALL hold the FSM state enum, the 7-segment glyph constants (0-9, minus, blank) and the default REFRESH_DIV.
REQ-028 The sequential converter SHALL be the sub-module bin2bcd_seq, with ports start, bin[8:0], busy, done, bcd[11:0]; out_display SHALL own scan and glyph logic.

Verification
REQ-029 Unsigned: value=8'd255, signed_mode=0, load pulse -> busy high 9 cycles; display 2,5,5; digit 3 blank.
REQ-030 Signed extremes: value=8'h80, signed_mode=1 -> minus,1,2,8; value=8'hFF -> minus plus '1' (LZB on) or minus,0,0,1 (LZB off).
REQ-031 Restart: load value=8'd7, then load value=8'd42 four cycles later -> 7 never appears; display 0,4,2 (LZB off) nine cycles after the second load.
REQ-032 Scan, REFRESH_DIV=4: digit_en = 0001,0010,0100,1000,0001, each held for exactly 4 cycles.
REQ-033 Reset: assert reset low three cycles after a load of 8'd99 -> outputs zero immediately without waiting for clk; after release, display shows '0'.
REQ-034 Sweep: all 256 values in both modes -> displayed digits match the decimal reference model.
